cell_test_sequencer: RTL

//  Sequences exhaustive truth-table tests of one selected standard cell
//  (AND2X1 ... XOR2X1) on the LibreSilicon test wafer. It drives every input

---
 rtl/cell_test_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cell_test_sequencer.sv
// cell_test_sequencer
//
// Runs an exhaustive truth-table test of one standard cell in the test array.
// Each input vector is driven onto the shared cell-input bus and held for
// SETTLE_CYCLES clocks. The selected cell's output is then sampled and compared
// against the host-supplied truth table. Mismatches are counted, and the first
// failing vector is recorded.
//
// Ports
//   wb_clk_i      : clock, all state changes on the rising edge
//   wb_rst_i      : synchronous active-high reset
//   start_i       : run request, only looked at while idle
//   cell_sel_i    : index of the cell under test
//   n_inputs_i    : input count of the cell (1..4)
//   tt_i          : expected output, bit v is Y for input vector v
//   y_i           : asynchronous outputs of all cells
//   vec_o         : input vector driven to the cells (bit0=A .. bit3=D)
//   cell_en_o     : one-hot enable of the cell under test
//   busy_o        : run in progress
//   done_o        : single-cycle end-of-run pulse (also for a rejected config)
//   err_o         : last run was rejected for a bad config
//   fail_count_o  : mismatches seen in the last run
//   first_fail_o  : first mismatching vector of the last run, 0 if none
module cell_test_sequencer #(
  parameter int NUM_CELLS     = 20,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [4:0]           cell_sel_i,
  input  logic [2:0]           n_inputs_i,
  input  logic [15:0]          tt_i,
  input  logic [NUM_CELLS-1:0] y_i,
  output logic [3:0]           vec_o,
  output logic [NUM_CELLS-1:0] cell_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [4:0]           fail_count_o,
  output logic [3:0]           first_fail_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0]           CNT_RELOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [NUM_CELLS-1:0] CELL_ONE   = NUM_CELLS'(1);

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [3:0]           vec, vec_nxt;
  logic [NUM_CELLS-1:0] cell_en, cell_en_nxt;
  logic                 err, err_nxt;
  logic [4:0]           fail_count, fail_count_nxt;
  logic [3:0]           first_fail, first_fail_nxt;

  logic [2:0]           n_cfg;
  logic [15:0]          tt_cfg;

  logic                 accept;
  logic                 cfg_bad;
  logic                 y_sel;
  logic                 last_vec;

  assign accept  = (state == IDLE) && start_i;
  assign cfg_bad = (int'(cell_sel_i) >= NUM_CELLS) || (n_inputs_i == 3'd0) ||
                   (n_inputs_i > 3'd4);

  // cell_en already holds the latched selection as a one-hot mask, so the
  // output mux reduces to an AND-OR and never indexes past the array.
  assign y_sel    = |(y_i & cell_en);
  assign last_vec = (vec == 4'((5'd1 << n_cfg) - 5'd1));

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    vec_nxt        = vec;
    cell_en_nxt    = cell_en;
    err_nxt        = err;
    fail_count_nxt = fail_count;
    first_fail_nxt = first_fail;
    case (state)
      IDLE: begin
        if (start_i) begin
          fail_count_nxt = '0;
          first_fail_nxt = '0;
          err_nxt        = 1'b0;
          if (cfg_bad) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            vec_nxt     = '0;
            cell_en_nxt = CELL_ONE << cell_sel_i;
            cnt_nxt     = CNT_RELOAD;
            state_nxt   = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      SAMPLE: begin
        if (y_sel != tt_cfg[vec]) begin
          fail_count_nxt = fail_count + 5'd1;
          if (fail_count == 5'd0) begin
            first_fail_nxt = vec;
          end
        end
        if (last_vec) begin
          state_nxt = DONE;
        end else begin
          vec_nxt   = vec + 4'd1;
          cnt_nxt   = CNT_RELOAD;
          state_nxt = SETTLE;
        end
      end
      DONE: begin
        vec_nxt     = '0;
        cell_en_nxt = '0;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      vec        <= '0;
      cell_en    <= '0;
      err        <= 1'b0;
      fail_count <= '0;
      first_fail <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      vec        <= vec_nxt;
      cell_en    <= cell_en_nxt;
      err        <= err_nxt;
      fail_count <= fail_count_nxt;
      first_fail <= first_fail_nxt;
    end
  end

  // Run configuration is captured on accept and held for the whole run.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      n_cfg  <= n_inputs_i;
      tt_cfg <= tt_i;
    end
  end

  assign vec_o        = vec;
  assign cell_en_o    = cell_en;
  assign busy_o       = (state == SETTLE) || (state == SAMPLE);
  assign done_o       = (state == DONE);
  assign err_o        = err;
  assign fail_count_o = fail_count;
  assign first_fail_o = first_fail;

endmodule
